// File: rtl/d_cache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a whole-cache flush.
// Valid/ready request side toward the core, word-wide beat port toward memory.
module d_cache_wb #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE
    } state_t;

    state_t state_reg;

    logic [DATA_W-1:0] data_mem [SETS*LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [SETS-1:0]   valid_reg;
    logic [SETS-1:0]   dirty_reg;

    logic              lat_write_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [DATA_W-1:0] lat_wdata_reg;
    logic [OFF_W-1:0]  word_cnt_reg;
    logic [IDX_W-1:0]  set_cnt_reg;

    logic [TAG_W-1:0] req_tag, lat_tag;
    logic [IDX_W-1:0] req_idx, lat_idx, set_inc;
    logic [OFF_W-1:0] req_off, lat_off, word_inc;
    logic             hit, accept;

    assign {req_tag, req_idx, req_off} = req_addr;
    assign {lat_tag, lat_idx, lat_off} = lat_addr_reg;
    assign word_inc  = word_cnt_reg + OFF_W'(1);
    assign set_inc   = set_cnt_reg + IDX_W'(1);
    assign req_ready = (state_reg == IDLE) && !flush_req && !rst;
    assign accept    = req_valid && req_ready;
    assign hit       = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);

    // Single write port into the data array; no reset so it maps onto block RAM.
    logic                   dm_we;
    logic [IDX_W+OFF_W-1:0] dm_waddr;
    logic [DATA_W-1:0]      dm_wdata;

    always_comb begin
        dm_we    = 1'b0;
        dm_waddr = '0;
        dm_wdata = '0;
        if (!rst) begin
            case (state_reg)
                IDLE:        if (accept && hit && req_write) begin
                                 dm_we = 1'b1; dm_waddr = {req_idx, req_off}; dm_wdata = req_wdata;
                             end
                REFILL_WAIT: if (mem_resp_valid) begin
                                 dm_we = 1'b1; dm_waddr = {lat_idx, word_cnt_reg}; dm_wdata = mem_rdata;
                             end
                RESPOND:     if (lat_write_reg) begin
                                 dm_we = 1'b1; dm_waddr = {lat_idx, lat_off}; dm_wdata = lat_wdata_reg;
                             end
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we) data_mem[dm_waddr] <= dm_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            dirty_reg     <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            flush_done    <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_addr  <= '0;
            mem_wdata     <= '0;
            lat_write_reg <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            word_cnt_reg  <= '0;
            set_cnt_reg   <= '0;
        end else begin
            resp_valid <= 1'b0;
            flush_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (flush_req) begin
                        state_reg   <= FLUSH_SCAN;
                        set_cnt_reg <= '0;
                    end else if (accept && hit) begin
                        resp_valid <= 1'b1;
                        if (req_write) begin
                            resp_rdata         <= req_wdata;
                            dirty_reg[req_idx] <= 1'b1;
                        end else begin
                            resp_rdata <= data_mem[{req_idx, req_off}];
                        end
                    end else if (accept) begin
                        lat_write_reg <= req_write;
                        lat_addr_reg  <= req_addr;
                        lat_wdata_reg <= req_wdata;
                        word_cnt_reg  <= '0;
                        mem_req_valid <= 1'b1;
                        if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
                            state_reg     <= WRITEBACK;
                            mem_req_write <= 1'b1;
                            mem_req_addr  <= {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
                            mem_wdata     <= data_mem[{req_idx, {OFF_W{1'b0}}}];
                        end else begin
                            state_reg     <= REFILL_REQ;
                            mem_req_write <= 1'b0;
                            mem_req_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: if (mem_req_ready) begin
                    if (&word_cnt_reg) begin
                        state_reg     <= REFILL_REQ;
                        word_cnt_reg  <= '0;
                        mem_req_write <= 1'b0;
                        mem_req_addr  <= {lat_tag, lat_idx, {OFF_W{1'b0}}};
                    end else begin
                        word_cnt_reg <= word_inc;
                        mem_req_addr <= {tag_mem[lat_idx], lat_idx, word_inc};
                        mem_wdata    <= data_mem[{lat_idx, word_inc}];
                    end
                end
                REFILL_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state_reg     <= REFILL_WAIT;
                end
                REFILL_WAIT: if (mem_resp_valid) begin
                    if (&word_cnt_reg) begin
                        tag_mem[lat_idx]   <= lat_tag;
                        valid_reg[lat_idx] <= 1'b1;
                        dirty_reg[lat_idx] <= 1'b0;
                        state_reg          <= RESPOND;
                    end else begin
                        word_cnt_reg  <= word_inc;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {lat_tag, lat_idx, word_inc};
                        state_reg     <= REFILL_REQ;
                    end
                end
                RESPOND: begin
                    resp_valid <= 1'b1;
                    state_reg  <= IDLE;
                    if (lat_write_reg) begin
                        resp_rdata         <= lat_wdata_reg;
                        dirty_reg[lat_idx] <= 1'b1;
                    end else begin
                        resp_rdata <= data_mem[{lat_idx, lat_off}];
                    end
                end
                FLUSH_SCAN: begin
                    // Each set is invalidated as it is visited; the tag survives for the write-back.
                    valid_reg[set_cnt_reg] <= 1'b0;
                    dirty_reg[set_cnt_reg] <= 1'b0;
                    if (valid_reg[set_cnt_reg] && dirty_reg[set_cnt_reg]) begin
                        state_reg     <= FLUSH_WB;
                        word_cnt_reg  <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_write <= 1'b1;
                        mem_req_addr  <= {tag_mem[set_cnt_reg], set_cnt_reg, {OFF_W{1'b0}}};
                        mem_wdata     <= data_mem[{set_cnt_reg, {OFF_W{1'b0}}}];
                    end else if (&set_cnt_reg) begin
                        state_reg  <= FLUSH_DONE;
                        flush_done <= 1'b1;
                    end else begin
                        set_cnt_reg <= set_inc;
                    end
                end
                FLUSH_WB: if (mem_req_ready) begin
                    if (&word_cnt_reg) begin
                        mem_req_valid <= 1'b0;
                        if (&set_cnt_reg) begin
                            state_reg  <= FLUSH_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            set_cnt_reg <= set_inc;
                            state_reg   <= FLUSH_SCAN;
                        end
                    end else begin
                        word_cnt_reg <= word_inc;
                        mem_req_addr <= {tag_mem[set_cnt_reg], set_cnt_reg, word_inc};
                        mem_wdata    <= data_mem[{set_cnt_reg, word_inc}];
                    end
                end
                FLUSH_DONE: state_reg <= IDLE;
                default:    state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d_cache_wb.sv
// Scoreboard bench for d_cache_wb: a backing-memory model logs every beat, responses
// are queued by a monitor and matched against an architectural reference memory.
module tb_d_cache_wb;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata, resp_rdata;
    logic        resp_valid, flush_req, flush_done;
    logic        mem_req_valid, mem_req_ready, mem_req_write, mem_resp_valid;
    logic [15:0] mem_req_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    d_cache_wb #(.ADDR_W(16), .DATA_W(16), .SETS(16), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .flush_req(flush_req), .flush_done(flush_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct packed { logic w; logic [15:0] a; logic [15:0] d; } beat_t;
    typedef struct packed { logic [15:0] data; int acc; } exp_t;
    typedef struct packed { logic [15:0] data; int cyc; } obs_t;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    beat_t beat_q[$];
    obs_t  resp_q[$];
    exp_t  exp_q[$];
    int    done_q[$];

    logic [15:0] mem_model [0:1023];
    bit          mem_flag  [0:1023];
    logic [15:0] ref_mem   [0:1023];
    bit          ref_flag  [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    // Backing memory: unwritten words read as addr+0x100, reads return one cycle after the beat.
    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            beat_q.push_back('{w: mem_req_write, a: mem_req_addr,
                               d: mem_req_write ? mem_wdata : 16'h0});
            if (mem_req_write) begin
                mem_model[mem_req_addr[9:0]] <= mem_wdata;
                mem_flag[mem_req_addr[9:0]]  <= 1'b1;
            end
        end
        mem_resp_valid <= mem_req_valid && mem_req_ready && !mem_req_write;
        mem_rdata <= mem_flag[mem_req_addr[9:0]] ? mem_model[mem_req_addr[9:0]]
                                                 : mem_req_addr + 16'h0100;
    end

    always @(negedge clk) begin
        if (resp_valid === 1'b1) resp_q.push_back('{data: resp_rdata, cyc: cyc});
        if (flush_done === 1'b1) done_q.push_back(cyc);
    end

    function automatic logic [15:0] ref_get(input logic [15:0] a);
        return ref_flag[a[9:0]] ? ref_mem[a[9:0]] : a + 16'h0100;
    endfunction

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            $display("FAIL send_ready: req_ready never rose for addr %h", a);
        end
        e.acc = cyc + 1;
        if (w) begin
            ref_mem[a[9:0]] = d;
            ref_flag[a[9:0]] = 1'b1;
            e.data = d;
        end else begin
            e.data = ref_get(a);
        end
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int want, input int limit, output bit ok);
        int n;
        n = 0;
        while (resp_q.size() < want && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (resp_q.size() >= want);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || flush_done !== 1'b0 || mem_req_valid !== 1'b0)
            $display("FAIL reset_ctrl: got ready=%b resp=%b done=%b mvalid=%b, want all 0",
                     req_ready, resp_valid, flush_done, mem_req_valid);
        else passes++;
        checks++;
        if (mem_req_addr !== 16'h0 || mem_wdata !== 16'h0 || resp_rdata !== 16'h0 || mem_req_write !== 1'b0)
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h write=%b, want all 0",
                     mem_req_addr, mem_wdata, resp_rdata, mem_req_write);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b, want 1", req_ready);
        else passes++;
    endtask

    task automatic test_cold_miss();
        bit ok; obs_t r; exp_t e; beat_t g; beat_t eb[$];
        beat_q.delete(); resp_q.delete();
        send(1'b0, 16'h0013, 16'h0); drop();
        wait_resp(1, 40, ok);
        checks++;
        if (!ok) $display("FAIL cold_miss_resp: got no response, want data 0113");
        else begin
            r = resp_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e.data || r.cyc - e.acc + 1 != 10)
                $display("FAIL cold_miss_resp: got %h lat %0d, want %h lat 10", r.data, r.cyc - e.acc + 1, e.data);
            else passes++;
        end
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b0, a: 16'h0010 + 16'(i), d: 16'h0});
        checks++;
        if (beat_q.size() != eb.size()) $display("FAIL cold_miss_beats: got %0d beats, want %0d", beat_q.size(), eb.size());
        else passes++;
        foreach (eb[i]) begin
            g = '0;
            if (i < beat_q.size()) g = beat_q[i];
            checks++;
            if (g !== eb[i]) $display("FAIL cold_miss_beat%0d: got %h, want %h", i, g, eb[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok; obs_t r; exp_t e;
        beat_q.delete(); resp_q.delete();
        send(1'b0, 16'h0010, 16'h0);
        send(1'b0, 16'h0011, 16'h0);
        drop();
        wait_resp(2, 20, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!ok) $display("FAIL hit%0d_resp: got no response, want one", i);
            else begin
                r = resp_q.pop_front(); e = exp_q.pop_front();
                if (r.data !== e.data || r.cyc - e.acc + 1 != 1)
                    $display("FAIL hit%0d_resp: got %h lat %0d, want %h lat 1", i, r.data, r.cyc - e.acc + 1, e.data);
                else passes++;
            end
        end
        checks++;
        if (beat_q.size() != 0) $display("FAIL hit_no_traffic: got %0d beats, want 0", beat_q.size());
        else passes++;
    endtask

    task automatic test_dirty_evict();
        bit ok; obs_t r; exp_t e; beat_t g; beat_t eb[$];
        resp_q.delete();
        send(1'b1, 16'h0012, 16'hBEEF); drop();
        wait_resp(1, 20, ok);
        checks++;
        if (!ok) $display("FAIL store_hit_resp: got no response, want beef");
        else begin
            r = resp_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e.data || r.cyc - e.acc + 1 != 1)
                $display("FAIL store_hit_resp: got %h lat %0d, want %h lat 1", r.data, r.cyc - e.acc + 1, e.data);
            else passes++;
        end
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b1, a: 16'h0010 + 16'(i), d: ref_get(16'h0010 + 16'(i))});
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b0, a: 16'h0050 + 16'(i), d: 16'h0});
        beat_q.delete();
        send(1'b0, 16'h0052, 16'h0); drop();
        wait_resp(1, 60, ok);
        checks++;
        if (!ok) $display("FAIL dirty_miss_resp: got no response, want 0152");
        else begin
            r = resp_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e.data || r.cyc - e.acc + 1 != 14)
                $display("FAIL dirty_miss_resp: got %h lat %0d, want %h lat 14", r.data, r.cyc - e.acc + 1, e.data);
            else passes++;
        end
        checks++;
        if (beat_q.size() != eb.size()) $display("FAIL dirty_miss_beats: got %0d beats, want %0d", beat_q.size(), eb.size());
        else passes++;
        foreach (eb[i]) begin
            g = '0;
            if (i < beat_q.size()) g = beat_q[i];
            checks++;
            if (g !== eb[i]) $display("FAIL dirty_miss_beat%0d: got %h, want %h", i, g, eb[i]);
            else passes++;
        end
    endtask

    task automatic test_wb_stall();
        bit ok; obs_t r; exp_t e; beat_t g; beat_t eb[$];
        resp_q.delete();
        send(1'b1, 16'h0051, 16'h1234); drop();
        wait_resp(1, 20, ok);
        void'(resp_q.pop_front()); void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b1, a: 16'h0050 + 16'(i), d: ref_get(16'h0050 + 16'(i))});
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b0, a: 16'h0010 + 16'(i), d: 16'h0});
        beat_q.delete();
        send(1'b0, 16'h0011, 16'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_addr !== 16'h0051 || mem_wdata !== 16'h1234)
                $display("FAIL wb_stall_hold%0d: got v=%b w=%b addr=%h data=%h, want 1 1 0051 1234",
                         i, mem_req_valid, mem_req_write, mem_req_addr, mem_wdata);
            else passes++;
            if (i < 5) @(negedge clk);
        end
        mem_req_ready = 1'b1;
        wait_resp(1, 80, ok);
        checks++;
        if (!ok) $display("FAIL wb_stall_resp: got no response, want 0111");
        else begin
            r = resp_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e.data || r.cyc - e.acc + 1 != 19)
                $display("FAIL wb_stall_resp: got %h lat %0d, want %h lat 19", r.data, r.cyc - e.acc + 1, e.data);
            else passes++;
        end
        checks++;
        if (beat_q.size() != eb.size()) $display("FAIL wb_stall_beats: got %0d beats, want %0d", beat_q.size(), eb.size());
        else passes++;
        foreach (eb[i]) begin
            g = '0;
            if (i < beat_q.size()) g = beat_q[i];
            checks++;
            if (g !== eb[i]) $display("FAIL wb_stall_beat%0d: got %h, want %h", i, g, eb[i]);
            else passes++;
        end
    endtask

    task automatic test_flush();
        bit ok; obs_t r; exp_t e; beat_t g; beat_t eb[$]; int f; int n;
        resp_q.delete();
        send(1'b1, 16'h0001, 16'hA001); drop();
        send(1'b1, 16'h003E, 16'hA03E); drop();
        wait_resp(2, 80, ok);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (!ok) $display("FAIL flush_setup%0d: got no response, want one", i);
            else begin
                r = resp_q.pop_front(); e = exp_q.pop_front();
                if (r.data !== e.data || r.cyc - e.acc + 1 != 10)
                    $display("FAIL flush_setup%0d: got %h lat %0d, want %h lat 10", i, r.data, r.cyc - e.acc + 1, e.data);
                else passes++;
            end
        end
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b1, a: 16'h0000 + 16'(i), d: ref_get(16'h0000 + 16'(i))});
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b1, a: 16'h003C + 16'(i), d: ref_get(16'h003C + 16'(i))});
        beat_q.delete(); done_q.delete();
        @(negedge clk); flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
        n = 0;
        while (done_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        checks++;
        if (done_q.size() != 1) $display("FAIL flush_done_pulses: got %0d, want 1", done_q.size());
        else passes++;
        checks++;
        if (beat_q.size() != eb.size()) $display("FAIL flush_beats: got %0d beats, want %0d", beat_q.size(), eb.size());
        else passes++;
        foreach (eb[i]) begin
            g = '0;
            if (i < beat_q.size()) g = beat_q[i];
            checks++;
            if (g !== eb[i]) $display("FAIL flush_beat%0d: got %h, want %h", i, g, eb[i]);
            else passes++;
        end
        beat_q.delete(); resp_q.delete();
        send(1'b0, 16'h0000, 16'h0); drop();
        wait_resp(1, 40, ok);
        checks++;
        if (!ok) $display("FAIL post_flush_load: got no response, want 0100");
        else begin
            r = resp_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e.data || r.cyc - e.acc + 1 != 10 || beat_q.size() != 4)
                $display("FAIL post_flush_load: got %h lat %0d beats %0d, want %h lat 10 beats 4",
                         r.data, r.cyc - e.acc + 1, beat_q.size(), e.data);
            else passes++;
        end
        beat_q.delete(); done_q.delete();
        @(negedge clk); flush_req = 1'b1; f = cyc + 1;
        @(negedge clk); flush_req = 1'b0;
        n = 0;
        while (done_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (done_q.size() == 0) $display("FAIL clean_flush: got no flush_done, want one");
        else if (done_q[0] - f + 1 != 17 || beat_q.size() != 0)
            $display("FAIL clean_flush: got lat %0d beats %0d, want lat 17 beats 0", done_q[0] - f + 1, beat_q.size());
        else passes++;
    endtask

    task automatic test_reset_mid_refill();
        bit ok; obs_t r; exp_t e; beat_t g; beat_t eb[$]; int n;
        beat_q.delete(); resp_q.delete();
        send(1'b0, 16'h0024, 16'h0); drop();
        n = 0;
        while (beat_q.size() < 2 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (beat_q.size() != 2) $display("FAIL mid_reset_setup: got %0d beats, want 2", beat_q.size());
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL mid_reset_drop: got mvalid=%b resp=%b, want 0 0", mem_req_valid, resp_valid);
        else passes++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (resp_q.size() != 0 || beat_q.size() != 2 || req_ready !== 1'b1)
            $display("FAIL mid_reset_quiet: got resp %0d beats %0d ready %b, want 0 2 1",
                     resp_q.size(), beat_q.size(), req_ready);
        else passes++;
        for (int i = 0; i < 4; i++) eb.push_back('{w: 1'b0, a: 16'h0024 + 16'(i), d: 16'h0});
        beat_q.delete();
        send(1'b0, 16'h0024, 16'h0); drop();
        wait_resp(1, 40, ok);
        checks++;
        if (!ok) $display("FAIL mid_reset_reload: got no response, want 0124");
        else begin
            r = resp_q.pop_front(); e = exp_q.pop_front();
            if (r.data !== e.data || r.cyc - e.acc + 1 != 10)
                $display("FAIL mid_reset_reload: got %h lat %0d, want %h lat 10", r.data, r.cyc - e.acc + 1, e.data);
            else passes++;
        end
        foreach (eb[i]) begin
            g = '0;
            if (i < beat_q.size()) g = beat_q[i];
            checks++;
            if (g !== eb[i]) $display("FAIL mid_reset_beat%0d: got %h, want %h", i, g, eb[i]);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        flush_req = 1'b0; mem_req_ready = 1'b1;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_dirty_evict();
        test_wb_stall();
        test_flush();
        test_reset_mid_refill();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
